sram_controller: RTL and testbench

- Bridges the MEM stage's 32-bit word load/store requests onto the 16-bit external SRAM bus.
- Each word access is split into two half-word SRAM phases, low half first and high half second.
- readyOut stalls the whole pipeline while an access is in flight; it gates the IF freeze and the ID/EXE/MEM register enables.
- Sits between the MEM stage datapath (ALU result, Val_Rm, MEM_R/W enables) and the SRAM pins.

---
 rtl/sram_pkg.sv | 10 +
 rtl/sram_if.sv | 19 +
 rtl/sram_phase_counter.sv | 24 ++
 rtl/sram_controller.sv | 108 ++++++++++
 tb/tb_sram_controller.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM bridge: FSM state encoding, external bus
// widths and default parameter values.
package sram_pkg;
  localparam int SRAM_ADDR_W     = 18;
  localparam int SRAM_DATA_W     = 16;
  localparam int DEF_BASE_ADDR   = 1024;
  localparam int DEF_WAIT_CYCLES = 3;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;
endpackage

// File: rtl/sram_if.sv
// MEM-stage request bus between the pipeline and the SRAM controller.
//   wrEnIn/rdEnIn  : store/load request, held until readyOut=1
//   addressIn      : byte address (ALU result)
//   writeDataIn    : store data
//   readDataOut    : last loaded word
//   readyOut       : 1 = no access pending or access completing this cycle
interface sram_if;
  logic        wrEnIn;
  logic        rdEnIn;
  logic [31:0] addressIn;
  logic [31:0] writeDataIn;
  logic [31:0] readDataOut;
  logic        readyOut;

  modport master (output wrEnIn, rdEnIn, addressIn, writeDataIn,
                  input  readDataOut, readyOut);
  modport slave  (input  wrEnIn, rdEnIn, addressIn, writeDataIn,
                  output readDataOut, readyOut);
endinterface

// File: rtl/sram_phase_counter.sv
// Cycle counter for one half-word SRAM phase.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (has priority over en)
//   en       : count enable
//   tc       : terminal count, high while count == WAIT_CYCLES-1
module sram_phase_counter #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 4'd1;
  end

  assign tc = (cnt == 4'(WAIT_CYCLES - 1));
endmodule

// File: rtl/sram_controller.sv
// Bridges 32-bit word loads/stores from the MEM stage onto a 16-bit SRAM.
// Each word is two half-word phases (low half, then high half), each lasting
// WAIT_CYCLES clocks, followed by a one-cycle DONE in which readyOut=1.
//   clk, rst   : clock, async active-high reset
//   bus        : MEM-stage request bus (slave side)
//   SRAM_DQ    : bidirectional SRAM data
//   SRAM_ADDR  : half-word address, 0 when idle
//   SRAM_*_N   : byte lanes / chip / output enables tied active
//   SRAM_WE_N  : write strobe, low through both phases of a store
module sram_controller
  import sram_pkg::*;
#(
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_if.slave                  bus,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N
);
  state_e                 state_q, state_d;
  logic                   is_wr_q;
  logic [SRAM_DATA_W-1:0] low_half_q;
  logic [31:0]            read_data_q;
  logic                   req, active, tc;
  logic [16:0]            idx;
  logic                   dq_oe;
  logic [SRAM_DATA_W-1:0] dq_out;

  assign req    = bus.wrEnIn | bus.rdEnIn;
  assign active = (state_q == LOW) || (state_q == HIGH);
  // Word index wraps modulo 2^17; no range check on purpose.
  assign idx    = 17'((bus.addressIn - 32'(BASE_ADDR)) >> 2);

  sram_phase_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (~active | tc),
    .en  (active),
    .tc  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Requests are only looked at in IDLE; in DONE the pipeline is advancing
  // and the held request belongs to the access just finished.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = LOW;
      LOW:     if (tc)  state_d = HIGH;
      HIGH:    if (tc)  state_d = DONE;
      default:          state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_wr_q     <= 1'b0;
      low_half_q  <= '0;
      read_data_q <= '0;
    end else begin
      if (state_q == IDLE && req) is_wr_q <= bus.wrEnIn;  // write wins
      if (state_q == LOW && tc && !is_wr_q) low_half_q <= SRAM_DQ;
      if (state_q == HIGH && tc && !is_wr_q) read_data_q <= {SRAM_DQ, low_half_q};
    end
  end

  always_comb begin
    bus.readyOut = 1'b0;
    SRAM_ADDR    = '0;
    SRAM_WE_N    = 1'b1;
    dq_oe        = 1'b0;
    dq_out       = '0;
    case (state_q)
      IDLE: bus.readyOut = ~req;
      LOW: begin
        SRAM_ADDR = {idx, 1'b0};
        SRAM_WE_N = ~is_wr_q;
        dq_oe     = is_wr_q;
        dq_out    = bus.writeDataIn[15:0];
      end
      HIGH: begin
        SRAM_ADDR = {idx, 1'b1};
        SRAM_WE_N = ~is_wr_q;
        dq_oe     = is_wr_q;
        dq_out    = bus.writeDataIn[31:16];
      end
      default: bus.readyOut = 1'b1;
    endcase
  end

  assign bus.readDataOut = read_data_q;
  assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DATA_W{1'bz}};
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with an inline behavioural SRAM and a
// scoreboard queue of expected load results.
module tb_sram_controller;
  import sram_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire  [15:0] dq;
  logic [17:0] sram_addr;
  logic        ub_n, lb_n, ce_n, oe_n, we_n;

  int errors = 0;
  int checks = 0;

  logic [31:0] sb[$];
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd = 32'h0;
  logic [15:0] sram_mem [0:(1<<18)-1];

  sram_if bus();

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .SRAM_DQ   (dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n),
    .SRAM_WE_N (we_n)
  );

  always #5 clk = ~clk;

  // Async SRAM with OE tied active: drives the bus whenever not writing.
  assign dq = we_n ? sram_mem[sram_addr] : 16'bz;
  always @(posedge clk) if (!we_n) sram_mem[sram_addr] <= dq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request starting at a negedge and returns at the negedge of
  // the completing (readyOut=1) cycle. from_done: called from a DONE cycle,
  // so the request is first seen in the following IDLE cycle.
  task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] data, input logic from_done, input string tag);
    int low_cnt = 0;
    int we_cnt  = 0;
    logic drove = 1'b0;
    int widx = int'((addr - 32'd1024) >> 2);
    bus.wrEnIn = wr; bus.rdEnIn = rd; bus.addressIn = addr; bus.writeDataIn = data;
    if (wr) ref_mem[widx] = data;
    else if (rd) sb.push_back(ref_mem.exists(widx) ? ref_mem[widx] : 32'h0);
    if (from_done) @(negedge clk);
    else #1;
    while (!bus.readyOut && low_cnt < 50) begin
      low_cnt++;
      if (!we_n) we_cnt++;
      if (dut.dq_oe) drove = 1'b1;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, low_cnt, 7);
    check({tag, " we_low_cycles"}, we_cnt, wr ? 6 : 0);
    if (!wr) check({tag, " dq_not_driven"}, {31'b0, drove}, 32'h0);
    if (!wr && rd) begin
      if (sb.size() == 0) check({tag, " sb_empty"}, 32'h1, 32'h0);
      else begin
        last_rd = sb.pop_front();
        check({tag, " read_data"}, bus.readDataOut, last_rd);
      end
    end else begin
      check({tag, " read_data_held"}, bus.readDataOut, last_rd);
    end
  endtask

  task automatic idle_req();
    bus.wrEnIn = 1'b0; bus.rdEnIn = 1'b0; bus.addressIn = '0; bus.writeDataIn = '0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1<<18); i++) sram_mem[i] = 16'h0;
    bus.wrEnIn = 1'b0; bus.rdEnIn = 1'b0; bus.addressIn = '0; bus.writeDataIn = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst readData", bus.readDataOut, 32'h0);
    check("rst ready", {31'b0, bus.readyOut}, 32'h1);
    check("rst we_n", {31'b0, we_n}, 32'h1);
    check("rst addr", {14'b0, sram_addr}, 32'h0);
    check("rst dq_oe", {31'b0, dut.dq_oe}, 32'h0);
    check("tied pins", {28'b0, ub_n, lb_n, ce_n, oe_n}, 32'h0);
    rst = 1'b0;

    // Reset mid-LOW of a write, then restart with request still held
    bus.wrEnIn = 1'b1; bus.addressIn = 32'd1024; bus.writeDataIn = 32'h1111_2222;
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("midlow we_n", {31'b0, we_n}, 32'h0);
    rst = 1'b1;
    #1;
    check("midrst we_n", {31'b0, we_n}, 32'h1);
    check("midrst dq_oe", {31'b0, dut.dq_oe}, 32'h0);
    check("midrst ready", {31'b0, bus.readyOut}, 32'h0);
    check("midrst addr", {14'b0, sram_addr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    access(1'b1, 1'b0, 32'd1024, 32'h1111_2222, 1'b0, "restart_wr");
    idle_req();

    // Main write / read
    access(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 1'b0, "wr1024");
    check("sram[0]", {16'b0, sram_mem[0]}, 32'h0000_BEEF);
    check("sram[1]", {16'b0, sram_mem[1]}, 32'h0000_DEAD);
    idle_req();
    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, "rd1024");
    check("rd done ready", {31'b0, bus.readyOut}, 32'h1);
    idle_req();

    // Write 1028, then back-to-back reads
    access(1'b1, 1'b0, 32'd1028, 32'h1234_5678, 1'b0, "wr1028");
    check("sram[2]", {16'b0, sram_mem[2]}, 32'h0000_5678);
    check("sram[3]", {16'b0, sram_mem[3]}, 32'h0000_1234);
    idle_req();
    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, "b2b_rd1024");
    access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b1, "b2b_rd1028");
    idle_req();

    // Both enables: write wins
    access(1'b1, 1'b1, 32'd1032, 32'hA5A5_5A5A, 1'b0, "wr_rd_both");
    check("sram[4]", {16'b0, sram_mem[4]}, 32'h0000_5A5A);
    check("sram[5]", {16'b0, sram_mem[5]}, 32'h0000_A5A5);
    idle_req();
    check("post both readData", bus.readDataOut, 32'h1234_5678);

    // Quiet period
    for (int i = 0; i < 10; i++) begin
      check("idle ready", {31'b0, bus.readyOut}, 32'h1);
      check("idle addr", {14'b0, sram_addr}, 32'h0);
      check("idle we_n", {31'b0, we_n}, 32'h1);
      check("idle dq_oe", {31'b0, dut.dq_oe}, 32'h0);
      @(negedge clk);
    end

    check("sb drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
